// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns, one column per clock.
// Define MIX_COLUMNS_INV_EN to add the inv port and inverse mode.
module mix_columns_iter #(
  parameter int unsigned COLS     = 4,
  parameter logic [7:0]  RED_POLY = 8'h1B
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*COLS-1:0]   in_data,
`ifdef MIX_COLUMNS_INV_EN
  input  logic                 inv,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*COLS-1:0]   out_data,
  output logic                 busy
);

  localparam int unsigned W  = 32 * COLS;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [W-1:0]  src_reg;
`ifdef MIX_COLUMNS_INV_EN
  logic          inv_reg;
`endif

  logic [31:0] col_in;
  logic [31:0] col_out;
  logic [7:0]  a_b [4];
  logic [7:0]  t2  [4];
  logic [7:0]  k0  [4];
  logic [7:0]  k1  [4];
  logic [7:0]  k2  [4];
  logic [7:0]  k3  [4];
`ifdef MIX_COLUMNS_INV_EN
  logic [7:0]  t4  [4];
  logic [7:0]  t8  [4];
`endif

  function automatic logic [7:0] xt(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? RED_POLY : 8'h00);
  endfunction

  always_comb begin
    col_in = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col == CW'(c))
        col_in = src_reg[W-1-32*c -: 32];
    end
  end

  // k0..k3 hold each byte times the four rotated coefficients
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      a_b[r] = col_in[31-8*r -: 8];
      t2[r]  = xt(a_b[r]);
`ifdef MIX_COLUMNS_INV_EN
      t4[r]  = xt(t2[r]);
      t8[r]  = xt(t4[r]);
      k0[r]  = inv_reg ? (t8[r] ^ t4[r] ^ t2[r])
                       : t2[r];
      k1[r]  = inv_reg ? (t8[r] ^ t2[r] ^ a_b[r])
                       : (t2[r] ^ a_b[r]);
      k2[r]  = inv_reg ? (t8[r] ^ t4[r] ^ a_b[r])
                       : a_b[r];
      k3[r]  = inv_reg ? (t8[r] ^ a_b[r])
                       : a_b[r];
`else
      k0[r]  = t2[r];
      k1[r]  = t2[r] ^ a_b[r];
      k2[r]  = a_b[r];
      k3[r]  = a_b[r];
`endif
    end
  end

  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      col_out[31-8*r -: 8] = k0[r]
                           ^ k1[(r+1)%4]
                           ^ k2[(r+2)%4]
                           ^ k3[(r+3)%4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      src_reg   <= '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_reg   <= 1'b0;
`endif
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            src_reg  <= in_data;
`ifdef MIX_COLUMNS_INV_EN
            inv_reg  <= inv;
`endif
            col      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          for (int c = 0; c < COLS; c++) begin
            if (col == CW'(c))
              out_data[W-1-32*c -: 32] <= col_out;
          end
          if (col == LAST) begin
            col       <= '0;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            col <= col + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: directed vectors plus a GF(2^8) reference model
// and a scoreboard compared on every valid output cycle.
`timescale 1ns/1ps
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [127:0] in_data = '0;
  logic [127:0] out_data;
`ifdef MIX_COLUMNS_INV_EN
  logic         inv = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic prev_ov = 1'b0;
  logic [127:0] exp_q[$];
  int hs_q[$];

  always #5 clk = ~clk;

  mix_columns_iter dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
`ifdef MIX_COLUMNS_INV_EN
    .inv(inv),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy)
  );

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input logic iv, input int k);
    case (k)
      0: return iv ? 8'h0e : 8'h02;
      1: return iv ? 8'h0b : 8'h03;
      2: return iv ? 8'h0d : 8'h01;
      default: return iv ? 8'h09 : 8'h01;
    endcase
  endfunction

  // b_r = sum over j of coef[(j-r) mod 4] * a_j, per column
  function automatic logic [127:0] mix_state(
    input logic [127:0] s,
    input logic iv
  );
    logic [127:0] res = '0;
    logic [7:0] acc;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef(iv, (j - r + 4) % 4),
                           s[127-32*c-8*j -: 8]);
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic chk(
    input string name,
    input logic [127:0] act,
    input logic [127:0] req
  );
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        hs_q.push_back(cyc);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        acc_cyc = cyc;
`ifdef MIX_COLUMNS_INV_EN
        exp_q.push_back(mix_state(in_data, inv));
`else
        exp_q.push_back(mix_state(in_data, 1'b0));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {127'd0, out_valid}, 128'd0);
      end else begin
        chk("sb_data", out_data, exp_q[0]);
        if (!prev_ov)
          chk("latency", 128'(cyc - acc_cyc), 128'd4);
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [127:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 128'd0, 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", {127'd0, out_valid}, 128'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("take_ov", {127'd0, out_valid}, 128'd0);
    chk("take_ir", {127'd0, in_ready}, 128'd1);
  endtask

  logic [127:0] fips_in, fips_out, id_in, id_out;
  logic [127:0] st_a, st_b, snap;
  logic [127:0] s3[3];

  initial begin
    fips_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    fips_out = 128'h046681e5e0cb199a48f8d37a2806264c;
    id_in    = 128'hdb135345f20a225c01010101c6c6c6c6;
    id_out   = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    st_a     = 128'h00112233445566778899aabbccddeeff;
    st_b     = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    s3[0]    = 128'h63636363fa1b2c3d80808080ffeeddcc;
    s3[1]    = 128'h0123456789abcdeffedcba9876543210;
    s3[2]    = 128'h5a5a5a5aa5a5a5a51b1b1b1b12345678;

    chk("model_fips", mix_state(fips_in, 1'b0), fips_out);
    chk("model_ident", mix_state(id_in, 1'b0), id_out);
    chk("model_inv", mix_state(fips_out, 1'b1), fips_in);

    repeat (2) @(negedge clk);
    chk("rst_ir", {127'd0, in_ready}, 128'd1);
    chk("rst_ov", {127'd0, out_valid}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_data", out_data, 128'd0);
    rst = 1'b0;

    send(fips_in);
    chk("calc_busy", {127'd0, busy}, 128'd1);
    chk("calc_ir", {127'd0, in_ready}, 128'd0);
    wait_valid();
    chk("fips_out", out_data, fips_out);
    take();

    send(id_in);
    wait_valid();
    for (int c = 0; c < 4; c++)
      chk("ident_col", 128'(out_data[127-32*c -: 32]),
          128'(id_out[127-32*c -: 32]));
    take();

    send(st_a);
    wait_valid();
    snap = mix_state(st_a, 1'b0);
    in_valid = 1'b1;
    in_data = st_b;
    repeat (10) begin
      @(negedge clk);
      chk("bp_data", out_data, snap);
      chk("bp_ir", {127'd0, in_ready}, 128'd0);
      chk("bp_ov", {127'd0, out_valid}, 128'd1);
    end
    take();
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp2_busy", {127'd0, busy}, 128'd1);
    wait_valid();
    chk("bp2_data", out_data, mix_state(st_b, 1'b0));
    take();

    hs_q.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      in_data = s3[i];
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_count", 128'(hs_q.size()), 128'd3);
    if (hs_q.size() >= 3) begin
      chk("b2b_gap1", 128'(hs_q[1] - hs_q[0]), 128'd6);
      chk("b2b_gap2", 128'(hs_q[2] - hs_q[1]), 128'd6);
    end
    chk("b2b_drain", 128'(exp_q.size()), 128'd0);

    send(fips_in);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ir", {127'd0, in_ready}, 128'd1);
    chk("mrst_ov", {127'd0, out_valid}, 128'd0);
    chk("mrst_busy", {127'd0, busy}, 128'd0);
    chk("mrst_data", out_data, 128'd0);
    chk("mrst_q", 128'(exp_q.size()), 128'd0);
    repeat (6) @(negedge clk);
    chk("mrst_idle_ov", {127'd0, out_valid}, 128'd0);
    send(fips_in);
    wait_valid();
    chk("mrst_fips", out_data, fips_out);
    take();

`ifdef MIX_COLUMNS_INV_EN
    inv = 1'b1;
    send(fips_out);
    wait_valid();
    chk("inv_fips", out_data, fips_in);
    take();
    inv = 1'b0;
    send(fips_in);
    wait_valid();
    chk("fwd_again", out_data, fips_out);
    take();
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
